// File: rtl/ttrng.sv
// ttrng: TRNG tile. Raw entropy bit -> optional Von Neumann debias -> 32-bit Galois LFSR whitener, plus stuck-source monitor.
// Optional internal ring-oscillator source compiled in with `define TTRNG_RING_OSC_EN (selected by ui_in[3]).
module ttrng #(
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter logic [31:0] POLY       = 32'h8020_0003,
    parameter int          HEALTH_RUN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int               RUN_W   = $clog2(HEALTH_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HEALTH_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    // One whitener step; an all-zero result would lock the LFSR, so reload the seed instead.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic b);
        logic [31:0] n;
        n = (s >> 1) ^ ((s[0] ^ b) ? POLY : 32'h0);
        return (n == 32'h0) ? SEED : n;
    endfunction

    logic             w_raw;
    logic             w_deb_en;
    logic             w_acc;
    logic             w_bit;
    logic             w_pair_full_nx;
    logic             w_pair_bit_nx;
    logic [31:0]      w_lfsr_nx;
    logic [RUN_W-1:0] w_run_nx;
    logic             w_unused;

    logic [31:0]      r_lfsr;
    logic [7:0]       r_byte;
    logic [2:0]       r_bit_cnt;
    logic             r_strobe;
    logic             r_health;
    logic             r_pair_full;
    logic             r_pair_bit;
    logic             r_deb_prev;
    logic [RUN_W-1:0] r_run;
    logic             r_prev;

`ifdef TTRNG_RING_OSC_EN
    (* keep, dont_touch = "true" *) logic [2:0] w_ro;
    logic r_sync1;
    logic r_sync2;

    assign w_ro[0] = ~w_ro[2];
    assign w_ro[1] = ~w_ro[0];
    assign w_ro[2] = ~w_ro[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (ena) begin
            r_sync1 <= w_ro[2];
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = ui_in[3] ? r_sync2 : ui_in[0];
`else
    assign w_raw = ui_in[0];
`endif

    assign w_deb_en = ui_in[1];
    assign w_unused = ^{uio_in, ui_in[7:2]};

    // A change of debias mode since the last enabled cycle discards any half-filled pair.
    always_comb begin
        w_acc          = 1'b0;
        w_bit          = w_raw;
        w_pair_full_nx = 1'b0;
        w_pair_bit_nx  = r_pair_bit;
        if (!w_deb_en) begin
            w_acc = 1'b1;
        end else if (r_pair_full && (r_deb_prev == w_deb_en)) begin
            w_acc = (r_pair_bit != w_raw);
            w_bit = r_pair_bit;
        end else begin
            w_pair_full_nx = 1'b1;
            w_pair_bit_nx  = w_raw;
        end
    end

    assign w_lfsr_nx = lfsr_step(r_lfsr, w_bit);
    assign w_run_nx  = ((r_run == '0) || (w_raw != r_prev)) ? RUN_ONE :
                       (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= SEED;
            r_byte      <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_strobe    <= 1'b0;
            r_health    <= 1'b0;
            r_pair_full <= 1'b0;
            r_pair_bit  <= 1'b0;
            r_deb_prev  <= 1'b0;
            r_run       <= '0;
            r_prev      <= 1'b0;
        end else if (!ena) begin
            r_strobe <= 1'b0;
        end else begin
            r_deb_prev  <= w_deb_en;
            r_pair_full <= w_pair_full_nx;
            r_pair_bit  <= w_pair_bit_nx;
            r_run       <= w_run_nx;
            r_prev      <= w_raw;
            r_health    <= r_health | (w_run_nx == RUN_MAX);
            r_strobe    <= 1'b0;
            if (w_acc) begin
                r_lfsr    <= w_lfsr_nx;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte   <= w_lfsr_nx[7:0];
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    assign uo_out  = r_byte;
    assign uio_out = {6'b00_0000, r_health, r_strobe};
    assign uio_oe  = 8'b0000_0011;
endmodule

// File: tb/tb_ttrng.sv
// Self-checking bench for ttrng: directed test-plan steps plus randomized traffic against a behavioural model.
module tb_ttrng;
    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int          HRUN = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    ttrng dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_lfsr;
    logic [7:0]  m_byte;
    int          m_nacc;
    int          m_nsamp;
    int          m_run;
    bit          m_prev;
    bit          m_health;
    bit          m_strobe;
    bit          m_deb_last;
    bit          pairq[$];

    task automatic m_reset();
        m_lfsr = SEED; m_byte = 8'h00; m_nacc = 0; m_nsamp = 0; m_run = 0;
        m_prev = 1'b0; m_health = 1'b0; m_strobe = 1'b0; m_deb_last = 1'b0;
        pairq.delete();
    endtask

    task automatic m_step(input bit e, input logic [7:0] u);
        bit r, deb, acc, b;
        logic [31:0] nx;
        m_strobe = 1'b0;
        if (!e) return;
        r = u[0]; deb = u[1]; acc = 1'b0; b = r;
        if (deb != m_deb_last) pairq.delete();
        m_deb_last = deb;
        if (!deb) acc = 1'b1;
        else begin
            pairq.push_back(r);
            if (pairq.size() == 2) begin
                if (pairq[0] != pairq[1]) begin acc = 1'b1; b = pairq[0]; end
                pairq.delete();
            end
        end
        if (m_nsamp == 0 || r != m_prev) m_run = 1;
        else if (m_run < HRUN) m_run++;
        m_prev = r; m_nsamp++;
        if (m_run >= HRUN) m_health = 1'b1;
        if (acc) begin
            nx = (m_lfsr >> 1) ^ (((m_lfsr[0] ^ b) != 1'b0) ? POLY : 32'h0);
            m_lfsr = (nx == 0) ? SEED : nx;
            m_nacc++;
            if (m_nacc % 8 == 0) begin m_byte = m_lfsr[7:0]; m_strobe = 1'b1; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " uo_out"}, {24'h0, uo_out}, {24'h0, m_byte});
        chk({tag, " strobe"}, {31'h0, uio_out[0]}, {31'h0, m_strobe});
        chk({tag, " health"}, {31'h0, uio_out[1]}, {31'h0, m_health});
        chk({tag, " uio_hi"}, {26'h0, uio_out[7:2]}, 32'h0);
        chk({tag, " uio_oe"}, {24'h0, uio_oe}, 32'h3);
        chk({tag, " lfsr"}, dut.r_lfsr, m_lfsr);
    endtask

    task automatic step(input bit e, input logic [7:0] u, input string tag);
        ena = e; ui_in = u; uio_in = 8'($urandom);
        @(posedge clk);
        m_step(e, u);
        #1 chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1 m_reset();
        chk_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int strobes, first;
        bit deb, stick, cur;

        // Test 1: eight zero bits from reset
        do_reset("reset");
        for (int i = 1; i <= 8; i++) step(1'b1, 8'h00, "t1");
        chk("t1 byte", {24'h0, uo_out}, 32'h02);
        chk("t1 strobe", {31'h0, uio_out[0]}, 32'h1);
        chk("t1 lfsr", dut.r_lfsr, 32'hDB36C002);
        step(1'b1, 8'h00, "t1 after");
        chk("t1 strobe drop", {31'h0, uio_out[0]}, 32'h0);

        // Test 2: freeze window between cycles 4 and 5
        do_reset("t2 reset");
        for (int i = 1; i <= 4; i++) step(1'b1, 8'h00, "t2 pre");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, "t2 frozen");
            chk("t2 frozen byte", {24'h0, uo_out}, 32'h0);
            chk("t2 frozen strobe", {31'h0, uio_out[0]}, 32'h0);
        end
        for (int i = 5; i <= 8; i++) step(1'b1, 8'h00, "t2 post");
        chk("t2 byte", {24'h0, uo_out}, 32'h02);
        chk("t2 lfsr", dut.r_lfsr, 32'hDB36C002);

        // Test 3: debias on, constant 0
        do_reset("t3 reset");
        strobes = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 8'h02, "t3");
            strobes += int'(uio_out[0]);
            if (i == 31) chk("t3 health@31", {31'h0, uio_out[1]}, 32'h0);
            if (i == 32) chk("t3 health@32", {31'h0, uio_out[1]}, 32'h1);
        end
        chk("t3 strobes", strobes, 0);
        chk("t3 byte", {24'h0, uo_out}, 32'h0);
        chk("t3 lfsr", dut.r_lfsr, SEED);

        // Test 4: debias on, alternating 0,1
        do_reset("t4 reset");
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, {7'b0000001, 1'(i % 2 == 0)}, "t4");
            if (first == 0 && uio_out[0]) begin
                first = i;
                chk("t4 byte", {24'h0, uo_out}, 32'h02);
            end
        end
        chk("t4 first strobe", first, 16);

        // Test 5: toggling raw bit, 100 clocks
        do_reset("t5 reset");
        strobes = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, {7'b0, 1'(i % 2)}, "t5");
            strobes += int'(uio_out[0]);
            if (i % 8 == 0) chk("t5 strobe slot", {31'h0, uio_out[0]}, 32'h1);
        end
        chk("t5 strobes", strobes, 12);
        chk("t5 health", {31'h0, uio_out[1]}, 32'h0);

        // Test 6: reset mid-byte, then rerun test 1
        do_reset("t6 reset");
        for (int i = 1; i <= 5; i++) step(1'b1, 8'h00, "t6 pre");
        do_reset("t6 midreset");
        chk("t6 byte cleared", {24'h0, uo_out}, 32'h0);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'h00, "t6 post");
        chk("t6 byte", {24'h0, uo_out}, 32'h02);
        chk("t6 strobe", {31'h0, uio_out[0]}, 32'h1);
        chk("t6 lfsr", dut.r_lfsr, 32'hDB36C002);

        // Randomized traffic
        do_reset("rnd reset");
        deb = 1'b0; cur = 1'b0;
        for (int blk = 0; blk < 30; blk++) begin
            if ($urandom_range(0, 5) == 0) do_reset("rnd reset");
            stick = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 80; i++) begin
                logic [7:0] u;
                if ($urandom_range(0, 19) == 0) deb = ~deb;
                if (!stick || $urandom_range(0, 49) == 0) cur = 1'($urandom);
                u = 8'($urandom);
                u[0] = cur; u[1] = deb;
                step($urandom_range(0, 7) != 0, u, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
